// File: rtl/holy_axi_arbiter_pkg.sv
// holy_core_pkg: shared cache and arbiter state types for the holy core memory subsystem.
// arb_state_t lives next to cache_state_t so caches and arbiter agree on encodings.
package holy_core_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SENDING_WRITE_REQ,
        SENDING_WRITE_DATA,
        WAITING_WRITE_RES,
        SENDING_READ_REQ,
        RECEIVING_READ_DATA
    } cache_state_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_SERVE_I,
        ARB_SERVE_D
    } arb_state_t;

    typedef enum logic {
        ICACHE,
        DCACHE
    } grant_t;

endpackage

// File: rtl/holy_axi_arbiter_if.sv
// axi_if: AXI4 bundle with master/slave views, shared by the caches, the arbiter and memory.
interface axi_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arvalid;
    logic                    arready;
    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/holy_axi_arbiter.sv
// holy_axi_arbiter: shares one AXI memory port between the I- and D-cache, grant held until read rlast.
// HOLY_ARB_ROUND_ROBIN_EN selects round-robin ties; otherwise the D-cache has fixed priority.
module holy_axi_arbiter
    import holy_core_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         aclk,
    input  logic         rst_n,
    axi_if.slave         s_axi_icache,
    axi_if.slave         s_axi_dcache,
    input  cache_state_t i_cache_state,
    input  cache_state_t d_cache_state,
    axi_if.master        m_axi,
    output arb_state_t   arb_state,
    output logic         timeout_err
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] WD_MAX = CW'(TIMEOUT_CYCLES);

    logic          sel_i, sel_d, serving;
    logic          i_req, d_req, pick_d;
    logic          r_done, any_hs;
    logic [CW-1:0] wd_cnt, wd_nxt;

    assign sel_i   = arb_state == ARB_SERVE_I;
    assign sel_d   = arb_state == ARB_SERVE_D;
    assign serving = sel_i | sel_d;
    assign i_req   = i_cache_state != IDLE;
    assign d_req   = d_cache_state != IDLE;

`ifdef HOLY_ARB_ROUND_ROBIN_EN
    grant_t last_grant;
    assign pick_d = d_req & (!i_req | last_grant == ICACHE);
`else
    assign pick_d = d_req;
`endif

    // valids and readies toward memory are gated by the grant, so reset drops them immediately
    assign m_axi.awid    = sel_d ? s_axi_dcache.awid    : s_axi_icache.awid;
    assign m_axi.awaddr  = sel_d ? s_axi_dcache.awaddr  : s_axi_icache.awaddr;
    assign m_axi.awlen   = sel_d ? s_axi_dcache.awlen   : s_axi_icache.awlen;
    assign m_axi.awsize  = sel_d ? s_axi_dcache.awsize  : s_axi_icache.awsize;
    assign m_axi.awburst = sel_d ? s_axi_dcache.awburst : s_axi_icache.awburst;
    assign m_axi.awvalid = sel_d ? s_axi_dcache.awvalid : sel_i & s_axi_icache.awvalid;
    assign m_axi.wdata   = sel_d ? s_axi_dcache.wdata   : s_axi_icache.wdata;
    assign m_axi.wstrb   = sel_d ? s_axi_dcache.wstrb   : s_axi_icache.wstrb;
    assign m_axi.wlast   = sel_d ? s_axi_dcache.wlast   : s_axi_icache.wlast;
    assign m_axi.wvalid  = sel_d ? s_axi_dcache.wvalid  : sel_i & s_axi_icache.wvalid;
    assign m_axi.bready  = sel_d ? s_axi_dcache.bready  : sel_i & s_axi_icache.bready;
    assign m_axi.arid    = sel_d ? s_axi_dcache.arid    : s_axi_icache.arid;
    assign m_axi.araddr  = sel_d ? s_axi_dcache.araddr  : s_axi_icache.araddr;
    assign m_axi.arlen   = sel_d ? s_axi_dcache.arlen   : s_axi_icache.arlen;
    assign m_axi.arsize  = sel_d ? s_axi_dcache.arsize  : s_axi_icache.arsize;
    assign m_axi.arburst = sel_d ? s_axi_dcache.arburst : s_axi_icache.arburst;
    assign m_axi.arvalid = sel_d ? s_axi_dcache.arvalid : sel_i & s_axi_icache.arvalid;
    assign m_axi.rready  = sel_d ? s_axi_dcache.rready  : sel_i & s_axi_icache.rready;

    assign s_axi_icache.awready = sel_i & m_axi.awready;
    assign s_axi_icache.wready  = sel_i & m_axi.wready;
    assign s_axi_icache.bvalid  = sel_i & m_axi.bvalid;
    assign s_axi_icache.arready = sel_i & m_axi.arready;
    assign s_axi_icache.rvalid  = sel_i & m_axi.rvalid;
    assign s_axi_icache.bid     = m_axi.bid;
    assign s_axi_icache.bresp   = m_axi.bresp;
    assign s_axi_icache.rid     = m_axi.rid;
    assign s_axi_icache.rdata   = m_axi.rdata;
    assign s_axi_icache.rresp   = m_axi.rresp;
    assign s_axi_icache.rlast   = m_axi.rlast;

    assign s_axi_dcache.awready = sel_d & m_axi.awready;
    assign s_axi_dcache.wready  = sel_d & m_axi.wready;
    assign s_axi_dcache.bvalid  = sel_d & m_axi.bvalid;
    assign s_axi_dcache.arready = sel_d & m_axi.arready;
    assign s_axi_dcache.rvalid  = sel_d & m_axi.rvalid;
    assign s_axi_dcache.bid     = m_axi.bid;
    assign s_axi_dcache.bresp   = m_axi.bresp;
    assign s_axi_dcache.rid     = m_axi.rid;
    assign s_axi_dcache.rdata   = m_axi.rdata;
    assign s_axi_dcache.rresp   = m_axi.rresp;
    assign s_axi_dcache.rlast   = m_axi.rlast;

    // only the final read beat releases; write responses of any kind keep the grant
    assign r_done = m_axi.rvalid & m_axi.rready & m_axi.rlast;
    assign any_hs = (m_axi.awvalid & m_axi.awready) | (m_axi.wvalid & m_axi.wready) |
                    (m_axi.bvalid & m_axi.bready) | (m_axi.arvalid & m_axi.arready) |
                    (m_axi.rvalid & m_axi.rready);
    assign wd_nxt = (!serving || any_hs) ? '0 : wd_cnt == WD_MAX ? wd_cnt : wd_cnt + CW'(1);

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            arb_state   <= ARB_IDLE;
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
`ifdef HOLY_ARB_ROUND_ROBIN_EN
            last_grant  <= ICACHE;
`endif
        end else begin
            arb_state   <= serving ? (r_done ? ARB_IDLE : arb_state) :
                           pick_d ? ARB_SERVE_D : i_req ? ARB_SERVE_I : ARB_IDLE;
            wd_cnt      <= wd_nxt;
            timeout_err <= timeout_err | (wd_nxt == WD_MAX);
`ifdef HOLY_ARB_ROUND_ROBIN_EN
            if (!serving && (pick_d || i_req)) last_grant <= pick_d ? DCACHE : ICACHE;
`endif
        end
    end

endmodule

// File: tb/tb_holy_axi_arbiter.sv
// tb_holy_axi_arbiter: directed scenarios for holy_axi_arbiter (builds with or without HOLY_ARB_ROUND_ROBIN_EN).
module tb_holy_axi_arbiter;
    import holy_core_pkg::*;

    logic         aclk = 1'b0;
    logic         rst_n = 1'b1;
    cache_state_t i_st, d_st;
    arb_state_t   arb_state;
    logic         timeout_err;
    int           checks = 0;
    int           errors = 0;

    axi_if ic();
    axi_if dc();
    axi_if m();

    holy_axi_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .aclk(aclk), .rst_n(rst_n),
        .s_axi_icache(ic), .s_axi_dcache(dc),
        .i_cache_state(i_st), .d_cache_state(d_st),
        .m_axi(m), .arb_state(arb_state), .timeout_err(timeout_err)
    );

    always #5 aclk = ~aclk;

    task clear_bus;
        ic.awid = '0; ic.awaddr = '0; ic.awlen = '0; ic.awsize = 3'd2; ic.awburst = 2'b01; ic.awvalid = 1'b0;
        ic.wdata = '0; ic.wstrb = '1; ic.wlast = 1'b0; ic.wvalid = 1'b0; ic.bready = 1'b0;
        ic.arid = '0; ic.araddr = '0; ic.arlen = '0; ic.arsize = 3'd2; ic.arburst = 2'b01; ic.arvalid = 1'b0; ic.rready = 1'b0;
        dc.awid = 4'd1; dc.awaddr = '0; dc.awlen = '0; dc.awsize = 3'd2; dc.awburst = 2'b01; dc.awvalid = 1'b0;
        dc.wdata = '0; dc.wstrb = '1; dc.wlast = 1'b0; dc.wvalid = 1'b0; dc.bready = 1'b0;
        dc.arid = 4'd1; dc.araddr = '0; dc.arlen = '0; dc.arsize = 3'd2; dc.arburst = 2'b01; dc.arvalid = 1'b0; dc.rready = 1'b0;
        m.awready = 1'b0; m.wready = 1'b0; m.bid = '0; m.bresp = 2'b00; m.bvalid = 1'b0;
        m.arready = 1'b0; m.rid = '0; m.rdata = '0; m.rresp = 2'b00; m.rlast = 1'b0; m.rvalid = 1'b0;
    endtask

    task do_ar(input logic is_d, input logic [31:0] addr);
        if (is_d) begin dc.arvalid = 1'b1; dc.araddr = addr; end
        else begin ic.arvalid = 1'b1; ic.araddr = addr; end
        m.arready = 1'b1;
        @(negedge aclk);
        ic.arvalid = 1'b0; dc.arvalid = 1'b0; m.arready = 1'b0;
    endtask

    task do_read(input logic is_d, input int n, output int bad);
        logic [31:0] exp_d;
        bad = 0;
        for (int b = 0; b < n; b++) begin
            exp_d = 32'hA500_0000 ^ b;
            m.rvalid = 1'b1; m.rdata = exp_d; m.rlast = (b == n - 1);
            if (is_d) dc.rready = 1'b1; else ic.rready = 1'b1;
            #1;
            if (is_d ? (dc.rvalid !== 1'b1 || dc.rdata !== exp_d || dc.rlast !== (b == n - 1) || ic.rvalid !== 1'b0)
                     : (ic.rvalid !== 1'b1 || ic.rdata !== exp_d || ic.rlast !== (b == n - 1) || dc.rvalid !== 1'b0))
                bad++;
            if (m.rready !== 1'b1) bad++;
            @(negedge aclk);
        end
        m.rvalid = 1'b0; m.rlast = 1'b0; ic.rready = 1'b0; dc.rready = 1'b0;
    endtask

    task test_reset;
        clear_bus; i_st = IDLE; d_st = SENDING_READ_REQ;
        #2 rst_n = 1'b0;
        ic.arvalid = 1'b1; dc.awvalid = 1'b1; dc.wvalid = 1'b1; ic.bready = 1'b1; ic.rready = 1'b1;
        m.awready = 1'b1; m.wready = 1'b1; m.bvalid = 1'b1; m.arready = 1'b1; m.rvalid = 1'b1;
        @(negedge aclk); @(negedge aclk);
        checks++; if (arb_state !== ARB_IDLE) begin errors++; $display("FAIL reset_state actual=%0d expected=%0d", arb_state, ARB_IDLE); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout actual=%b expected=0", timeout_err); end
        checks++; if ({m.awvalid, m.wvalid, m.bready, m.arvalid, m.rready} !== 5'b0)
            begin errors++; $display("FAIL reset_m_valids actual=%b expected=00000", {m.awvalid, m.wvalid, m.bready, m.arvalid, m.rready}); end
        checks++; if ({ic.awready, ic.wready, ic.bvalid, ic.arready, ic.rvalid, dc.awready, dc.wready, dc.bvalid, dc.arready, dc.rvalid} !== 10'b0)
            begin errors++; $display("FAIL reset_slave_side actual=%b expected=0", {ic.awready, ic.wready, ic.bvalid, ic.arready, ic.rvalid, dc.awready, dc.wready, dc.bvalid, dc.arready, dc.rvalid}); end
        clear_bus; d_st = IDLE; rst_n = 1'b1;
        @(negedge aclk);
        checks++; if (arb_state !== ARB_IDLE) begin errors++; $display("FAIL idle_no_req actual=%0d expected=%0d", arb_state, ARB_IDLE); end
    endtask

    task test_icache_read;
        int bad;
        i_st = SENDING_READ_REQ; ic.arvalid = 1'b1; ic.araddr = 32'h1000_0040; ic.arlen = 8'd127;
        #1;
        checks++; if (arb_state !== ARB_IDLE || m.arvalid !== 1'b0)
            begin errors++; $display("FAIL icache_cycle0 state=%0d arvalid=%b expected state=0 arvalid=0", arb_state, m.arvalid); end
        @(negedge aclk);
        checks++; if (arb_state !== ARB_SERVE_I) begin errors++; $display("FAIL icache_grant actual=%0d expected=%0d", arb_state, ARB_SERVE_I); end
        checks++; if (m.arvalid !== 1'b1 || m.araddr !== 32'h1000_0040 || m.arlen !== 8'd127)
            begin errors++; $display("FAIL icache_ar_fwd arvalid=%b araddr=%h arlen=%0d expected 1 10000040 127", m.arvalid, m.araddr, m.arlen); end
        do_ar(1'b0, 32'h1000_0040);
        i_st = RECEIVING_READ_DATA;
        do_read(1'b0, 128, bad);
        checks++; if (bad !== 0) begin errors++; $display("FAIL icache_beats bad_beats=%0d expected=0", bad); end
        checks++; if (arb_state !== ARB_IDLE) begin errors++; $display("FAIL icache_release actual=%0d expected=%0d", arb_state, ARB_IDLE); end
        i_st = IDLE;
    endtask

    task test_simultaneous;
        int bad;
        i_st = SENDING_READ_REQ; d_st = SENDING_READ_REQ; ic.arvalid = 1'b1; ic.araddr = 32'h2000_0000;
        @(negedge aclk);
        checks++; if (arb_state !== ARB_SERVE_D) begin errors++; $display("FAIL tie_first_grant actual=%0d expected=%0d", arb_state, ARB_SERVE_D); end
        m.arready = 1'b1; #1;
        checks++; if (m.arvalid !== 1'b0 || ic.arready !== 1'b0)
            begin errors++; $display("FAIL non_granted_isolation m_arvalid=%b ic_arready=%b expected 0 0", m.arvalid, ic.arready); end
        m.arready = 1'b0;
        do_ar(1'b1, 32'h3000_0000);
        do_read(1'b1, 4, bad);
        checks++; if (bad !== 0) begin errors++; $display("FAIL tie_d_beats bad_beats=%0d expected=0", bad); end
        checks++; if (arb_state !== ARB_IDLE) begin errors++; $display("FAIL tie_idle_gap actual=%0d expected=%0d", arb_state, ARB_IDLE); end
        d_st = IDLE;
        @(negedge aclk);
        checks++; if (arb_state !== ARB_SERVE_I) begin errors++; $display("FAIL tie_then_i actual=%0d expected=%0d", arb_state, ARB_SERVE_I); end
        do_ar(1'b0, 32'h2000_0000);
        do_read(1'b0, 4, bad);
        checks++; if (bad !== 0 || arb_state !== ARB_IDLE)
            begin errors++; $display("FAIL tie_i_burst bad_beats=%0d state=%0d expected 0 0", bad, arb_state); end
        i_st = IDLE;
    endtask

    task test_repeated_ties;
        arb_state_t exp_g [4];
        logic g_d;
        int bad;
`ifdef HOLY_ARB_ROUND_ROBIN_EN
        exp_g = '{ARB_SERVE_D, ARB_SERVE_I, ARB_SERVE_D, ARB_SERVE_I};
`else
        exp_g = '{ARB_SERVE_D, ARB_SERVE_D, ARB_SERVE_D, ARB_SERVE_D};
`endif
        i_st = SENDING_READ_REQ; d_st = SENDING_READ_REQ;
        for (int k = 0; k < 4; k++) begin
            @(negedge aclk);
            checks++; if (arb_state !== exp_g[k]) begin errors++; $display("FAIL tie_seq_%0d actual=%0d expected=%0d", k, arb_state, exp_g[k]); end
            g_d = exp_g[k] == ARB_SERVE_D;
            do_ar(g_d, 32'h5000_0000 + 32'(k));
            do_read(g_d, 1, bad);
            checks++; if (bad !== 0 || arb_state !== ARB_IDLE)
                begin errors++; $display("FAIL tie_seq_release_%0d bad_beats=%0d state=%0d expected 0 0", k, bad, arb_state); end
        end
        i_st = IDLE; d_st = IDLE;
    endtask

    task test_dirty_miss;
        int bad;
        d_st = SENDING_WRITE_REQ;
        @(negedge aclk);
        checks++; if (arb_state !== ARB_SERVE_D) begin errors++; $display("FAIL dirty_grant actual=%0d expected=%0d", arb_state, ARB_SERVE_D); end
        dc.awvalid = 1'b1; dc.awaddr = 32'h4000_0000; dc.awlen = 8'd127; m.awready = 1'b1;
        #1;
        checks++; if (m.awvalid !== 1'b1 || m.awaddr !== 32'h4000_0000 || dc.awready !== 1'b1 || ic.awready !== 1'b0)
            begin errors++; $display("FAIL dirty_aw awvalid=%b awaddr=%h dc_awready=%b ic_awready=%b expected 1 40000000 1 0", m.awvalid, m.awaddr, dc.awready, ic.awready); end
        @(negedge aclk);
        dc.awvalid = 1'b0; m.awready = 1'b0;
        i_st = SENDING_READ_REQ; d_st = SENDING_WRITE_DATA; bad = 0;
        for (int b = 0; b < 128; b++) begin
            dc.wvalid = 1'b1; dc.wdata = 32'hD000_0000 + 32'(b); dc.wlast = (b == 127); m.wready = 1'b1;
            #1;
            if (m.wvalid !== 1'b1 || m.wdata !== 32'hD000_0000 + 32'(b) || m.wlast !== (b == 127) ||
                dc.wready !== 1'b1 || ic.wready !== 1'b0 || arb_state !== ARB_SERVE_D) bad++;
            @(negedge aclk);
        end
        dc.wvalid = 1'b0; dc.wlast = 1'b0; m.wready = 1'b0;
        checks++; if (bad !== 0) begin errors++; $display("FAIL dirty_w_beats bad_beats=%0d expected=0", bad); end
        d_st = WAITING_WRITE_RES; m.bvalid = 1'b1; m.bresp = 2'b00; dc.bready = 1'b1;
        #1;
        checks++; if (dc.bvalid !== 1'b1 || ic.bvalid !== 1'b0 || m.bready !== 1'b1 || dc.bresp !== 2'b00)
            begin errors++; $display("FAIL dirty_b dc_bvalid=%b ic_bvalid=%b bready=%b bresp=%b expected 1 0 1 00", dc.bvalid, ic.bvalid, m.bready, dc.bresp); end
        @(negedge aclk);
        m.bvalid = 1'b0; dc.bready = 1'b0;
        checks++; if (arb_state !== ARB_SERVE_D) begin errors++; $display("FAIL dirty_hold_after_b actual=%0d expected=%0d", arb_state, ARB_SERVE_D); end
        d_st = SENDING_READ_REQ;
        do_ar(1'b1, 32'h4000_0000);
        d_st = RECEIVING_READ_DATA;
        do_read(1'b1, 128, bad);
        checks++; if (bad !== 0 || arb_state !== ARB_IDLE)
            begin errors++; $display("FAIL dirty_read bad_beats=%0d state=%0d expected 0 0", bad, arb_state); end
        d_st = IDLE;
        @(negedge aclk);
        checks++; if (arb_state !== ARB_SERVE_I) begin errors++; $display("FAIL dirty_i_waited actual=%0d expected=%0d", arb_state, ARB_SERVE_I); end
        do_ar(1'b0, 32'h1000_0080);
        do_read(1'b0, 2, bad);
        i_st = IDLE;
    endtask

    task test_bresp_err;
        int bad;
        d_st = SENDING_WRITE_REQ;
        @(negedge aclk);
        dc.awvalid = 1'b1; m.awready = 1'b1;
        @(negedge aclk);
        dc.awvalid = 1'b0; m.awready = 1'b0; dc.wvalid = 1'b1; dc.wlast = 1'b1; m.wready = 1'b1;
        @(negedge aclk);
        dc.wvalid = 1'b0; dc.wlast = 1'b0; m.wready = 1'b0;
        m.bvalid = 1'b1; m.bresp = 2'b10; dc.bready = 1'b1;
        #1;
        checks++; if (dc.bvalid !== 1'b1 || dc.bresp !== 2'b10)
            begin errors++; $display("FAIL bresp_passthru bvalid=%b bresp=%b expected 1 10", dc.bvalid, dc.bresp); end
        @(negedge aclk);
        m.bvalid = 1'b0; m.bresp = 2'b00; dc.bready = 1'b0;
        checks++; if (arb_state !== ARB_SERVE_D) begin errors++; $display("FAIL bresp_no_release actual=%0d expected=%0d", arb_state, ARB_SERVE_D); end
        do_ar(1'b1, 32'h4000_0100);
        do_read(1'b1, 1, bad);
        checks++; if (arb_state !== ARB_IDLE) begin errors++; $display("FAIL bresp_rlast_release actual=%0d expected=%0d", arb_state, ARB_IDLE); end
        d_st = IDLE;
    endtask

    task test_watchdog;
        int bad;
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL wd_pre actual=%b expected=0", timeout_err); end
        i_st = SENDING_READ_REQ; ic.arvalid = 1'b1; ic.araddr = 32'h1000_1000; m.arready = 1'b0;
        @(negedge aclk);
        for (int c = 1; c <= 20; c++) begin
            @(negedge aclk);
            if (c == 15) begin
                checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL wd_stall15 actual=%b expected=0", timeout_err); end
            end
            if (c == 16) begin
                checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL wd_stall16 actual=%b expected=1", timeout_err); end
            end
        end
        checks++; if (arb_state !== ARB_SERVE_I) begin errors++; $display("FAIL wd_grant_kept actual=%0d expected=%0d", arb_state, ARB_SERVE_I); end
        do_ar(1'b0, 32'h1000_1000);
        do_read(1'b0, 8, bad);
        checks++; if (bad !== 0 || arb_state !== ARB_IDLE)
            begin errors++; $display("FAIL wd_burst_done bad_beats=%0d state=%0d expected 0 0", bad, arb_state); end
        i_st = IDLE;
        @(negedge aclk);
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL wd_sticky actual=%b expected=1", timeout_err); end
    endtask

    task test_reset_mid_burst;
        int bad;
        i_st = SENDING_READ_REQ;
        @(negedge aclk);
        do_ar(1'b0, 32'h1000_2000);
        i_st = RECEIVING_READ_DATA;
        for (int b = 0; b < 50; b++) begin
            m.rvalid = 1'b1; m.rdata = 32'(b); ic.rready = 1'b1;
            @(negedge aclk);
        end
        #1;
        checks++; if (m.rready !== 1'b1) begin errors++; $display("FAIL pre_reset_rready actual=%b expected=1", m.rready); end
        rst_n = 1'b0;
        #1;
        checks++; if (arb_state !== ARB_IDLE || m.rready !== 1'b0 || m.arvalid !== 1'b0 || ic.rvalid !== 1'b0)
            begin errors++; $display("FAIL reset_mid_burst state=%0d rready=%b arvalid=%b ic_rvalid=%b expected 0 0 0 0", arb_state, m.rready, m.arvalid, ic.rvalid); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_clears_timeout actual=%b expected=0", timeout_err); end
        clear_bus; i_st = IDLE;
        @(negedge aclk);
        rst_n = 1'b1;
        @(negedge aclk);
        i_st = SENDING_READ_REQ; d_st = SENDING_READ_REQ;
        @(negedge aclk);
        checks++; if (arb_state !== ARB_SERVE_D) begin errors++; $display("FAIL post_reset_tie actual=%0d expected=%0d", arb_state, ARB_SERVE_D); end
        do_ar(1'b1, 32'h3000_0040);
        do_read(1'b1, 1, bad);
        d_st = IDLE;
        @(negedge aclk);
        checks++; if (arb_state !== ARB_SERVE_I) begin errors++; $display("FAIL post_reset_i actual=%0d expected=%0d", arb_state, ARB_SERVE_I); end
        do_ar(1'b0, 32'h1000_3000);
        do_read(1'b0, 1, bad);
        i_st = IDLE;
        @(negedge aclk);
    endtask

    initial begin
        test_reset;
        test_icache_read;
        test_simultaneous;
        test_repeated_ties;
        test_dirty_miss;
        test_bresp_err;
        test_watchdog;
        test_reset_mid_burst;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/holy_axi_arbiter.md
HOLY_AXI_ARBITER -- requirements
Module: holy_axi_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning max cycles without any AXI handshake while granted before timeout_err.
REQ-002 SHALL have port aclk, input, 1, the single clock for all logic.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-004 SHALL have port s_axi_icache, axi_if.slave, -, instruction cache AXI port.
REQ-005 SHALL have port s_axi_dcache, axi_if.slave, -, data cache AXI port.
REQ-006 SHALL have port i_cache_state, input, cache_state_t, instruction cache FSM state.
REQ-007 SHALL have port d_cache_state, input, cache_state_t, data cache FSM state.
REQ-008 SHALL have port m_axi, axi_if.master, -, shared external memory port.
REQ-009 SHALL have port arb_state, output, arb_state_t, current arbiter state.
REQ-010 SHALL have port timeout_err, output, 1, sticky watchdog flag.

Function
REQ-011 Request SHALL be cache_state != IDLE on the corresponding cache.
REQ-012 FSM states SHALL be ARB_IDLE, ARB_SERVE_I and ARB_SERVE_D.
REQ-013 In ARB_IDLE with any request pending, the FSM SHALL enter the selected serve state on the next aclk edge, so grant latency is 1 cycle.
REQ-014 In ARB_IDLE, all m_axi valid/ready outputs SHALL be 0, and all slave-side awready, wready, bvalid, arready and rvalid SHALL be 0.
REQ-015 While serving, all master-bound signals SHALL be driven from the granted port.
- Covers aw*, w*, bready, ar*, rready.
REQ-016 While serving, m_axi responses SHALL be routed to the granted port only.
- Covers awready, wready, b*, arready, r*.
REQ-017 The non-granted port SHALL see all of awready, wready, bvalid, arready and rvalid at 0.
REQ-018 Grant SHALL be held across a dirty write-back burst and the following read burst.
REQ-019 Release SHALL occur only on a granted m_axi.rvalid & rready & rlast handshake, returning the FSM to ARB_IDLE next cycle.
REQ-020 No back-to-back grant SHALL occur without one ARB_IDLE cycle between grants.
REQ-021 A write response with bresp != OKAY SHALL be passed through unchanged and SHALL NOT release the grant.
REQ-022 Watchdog counter SHALL clear on any m_axi handshake (AW, W, B, AR or R) and in ARB_IDLE, and SHALL increment while serving otherwise.
REQ-023 On reaching TIMEOUT_CYCLES, timeout_err SHALL set and remain 1 until reset; arbitration SHALL continue unaffected.
REQ-024 The watchdog counter SHALL saturate at TIMEOUT_CYCLES and SHALL be $clog2(TIMEOUT_CYCLES+1) bits wide.
REQ-025 last_grant register SHALL update to the served port on entry to each serve state.

Reset
REQ-026 Asserting rst_n low SHALL immediately force arb_state to ARB_IDLE, clear timeout_err, clear the watchdog and set last_grant to ICACHE.
REQ-027 Reset mid-burst SHALL drop all m_axi valids to 0 combinationally, with no handshake completion required.
REQ-028 Reset values SHALL be arb_state = ARB_IDLE, timeout_err = 0, and all m_axi valid/ready = 0.

Configuration
REQ-029 Macro HOLY_ARB_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-030 When HOLY_ARB_ROUND_ROBIN_EN is defined, simultaneous requests SHALL grant the port not equal to last_grant, so DCACHE wins the first tie after reset.
REQ-031 When HOLY_ARB_ROUND_ROBIN_EN is undefined, DCACHE SHALL have fixed priority on simultaneous requests; last_grant is then unused.
REQ-032 A single pending request SHALL be granted immediately under both policies.

Structure
REQ-033 arb_state_t SHALL be defined in holy_core_pkg, alongside the existing cache_state_t.
REQ-034 Channel muxing SHALL be inline in this module; no sub-module is required.

Verification
REQ-035 I-cache only read miss: i_cache_state = SENDING_READ_REQ at cycle 0 -> ARB_SERVE_I at cycle 1; AR forwarded with araddr intact; 128 beats delivered; ARB_IDLE one cycle after rlast.
REQ-036 Simultaneous misses: both caches request in the same cycle -> DCACHE is granted in both modes; after release, ICACHE is granted after one idle cycle.
REQ-037 Repeated ties with HOLY_ARB_ROUND_ROBIN_EN: four consecutive ties -> grants D, I, D, I; without the macro -> D, D, D, D with I starved.
REQ-038 Dirty miss on D: write 128 beats, bresp OKAY, then read 128 beats -> grant held throughout; a concurrent I request waits until D's rlast.
REQ-039 Watchdog: TIMEOUT_CYCLES = 16, slave withholds arready for 20 cycles -> timeout_err = 1 at the 16th stalled cycle and stays 1 after the burst completes.
REQ-040 Async reset pulse at beat 50 of a read -> arb_state = ARB_IDLE and m_axi.rready = 0 within the same cycle; timeout_err = 0.
